// File: rtl/game_flow_controller.sv
// Round-level game FSM: IDLE/PLAY/HIT/GAME_OVER/WIN driven by lives/fruit counts, frame pulses and start key.
// Latency: all outputs registered, one clock after the sampled input; no backpressure, inputs are sampled every clock.
module game_flow_controller #(
    parameter int MAX_HITS     = 3,
    parameter int WIN_FRUITS   = 10,
    parameter int HIT_FRAMES   = 60,
    parameter int BLINK_FRAMES = 4,
    parameter int END_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       start_key,
    input  logic [1:0] current_lives,
    input  logic [3:0] fruit_cntr,
    output logic [2:0] game_state,
    output logic       play_enable,
    output logic       player_visible,
    output logic       show_game_over,
    output logic       show_win,
    output logic       counters_clear
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_HIT  = 3'd2,
        S_OVER = 3'd3,
        S_WIN  = 3'd4
    } state_t;

    localparam logic [1:0] MAX_HITS_W   = 2'(MAX_HITS);
    localparam logic [3:0] WIN_FRUITS_W = 4'(WIN_FRUITS);
    localparam logic [8:0] HIT_LAST     = 9'(HIT_FRAMES);
    localparam logic [8:0] END_LAST     = 9'(END_FRAMES);
    localparam logic [7:0] BLINK_LAST   = 8'(BLINK_FRAMES - 1);

    state_t     state;
    state_t     nxt;
    logic       key_d;
    logic       armed;
    logic [1:0] lives_d;
    logic [7:0] frame_cnt;
    logic [7:0] blink_cnt;

    logic       start_rise;
    logic       hit_event;
    logic       at_max;
    logic       won;
    logic [8:0] frame_inc;
    logic       hit_done;
    logic       end_done;
    logic       entry;
    logic       start_game;

    // armed stays low until the key is seen released after reset, so a key held through reset cannot start a round
    assign start_rise = start_key & ~key_d & armed;
    assign hit_event  = (current_lives != lives_d);
    assign at_max     = (current_lives == MAX_HITS_W);
    assign won        = (fruit_cntr >= WIN_FRUITS_W);
    assign frame_inc  = {1'b0, frame_cnt} + 9'd1;
    assign hit_done   = startOfFrame && (frame_inc == HIT_LAST);
    assign end_done   = startOfFrame && (frame_inc == END_LAST);
    assign entry      = (nxt != state);
    assign start_game = (state == S_IDLE) && (nxt == S_PLAY);
    assign game_state = state;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (start_rise) nxt = S_PLAY;
            end
            S_PLAY: begin
                if (at_max)         nxt = S_OVER;
                else if (hit_event) nxt = S_HIT;
                else if (won)       nxt = S_WIN;
            end
            S_HIT: begin
                if (at_max)        nxt = S_OVER;
                else if (hit_done) nxt = S_PLAY;
            end
            S_OVER, S_WIN: begin
                if (start_rise || end_done) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            key_d          <= 1'b0;
            armed          <= 1'b0;
            lives_d        <= 2'd0;
            frame_cnt      <= 8'd0;
            blink_cnt      <= 8'd0;
            play_enable    <= 1'b0;
            player_visible <= 1'b1;
            show_game_over <= 1'b0;
            show_win       <= 1'b0;
            counters_clear <= 1'b0;
        end else begin
            key_d          <= start_key;
            armed          <= armed | ~start_key;
            // the counter block returns to 0 during the clear cycle; that drop must not look like a hit
            lives_d        <= start_game ? 2'd0 : current_lives;
            state          <= nxt;
            counters_clear <= start_game;
            play_enable    <= (nxt == S_PLAY);
            show_game_over <= (nxt == S_OVER);
            show_win       <= (nxt == S_WIN);
            if (entry) begin
                frame_cnt      <= 8'd0;
                blink_cnt      <= 8'd0;
                player_visible <= (nxt != S_HIT) && (nxt != S_OVER);
            end else begin
                if (startOfFrame && (frame_cnt != 8'hFF)) frame_cnt <= frame_cnt + 8'd1;
                if ((state == S_HIT) && startOfFrame) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt      <= 8'd0;
                        player_visible <= ~player_visible;
                    end else begin
                        blink_cnt <= blink_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: fixed vector table, directed corner sequences and a random run against a reference model.
module tb_game_flow_controller;

    localparam int MAXH   = 3;
    localparam int WINF   = 10;
    localparam int HITF   = 3;
    localparam int BLINKF = 1;
    localparam int ENDF   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       start_key;
    logic [1:0] current_lives;
    logic [3:0] fruit_cntr;
    logic [2:0] game_state;
    logic       play_enable;
    logic       player_visible;
    logic       show_game_over;
    logic       show_win;
    logic       counters_clear;

    int errors = 0;
    int checks = 0;

    // reference model: state code, pulses seen since entering it, previous key/lives, key-released flag
    int m_st;
    int m_frames;
    int m_lives;
    bit m_key;
    bit m_armed;
    bit m_clear;

    typedef struct {
        bit key;
        bit sof;
        int lives;
        int fruit;
        int st;
        bit clr;
        bit vis;
    } vec_t;

    vec_t tbl[14];

    game_flow_controller #(
        .MAX_HITS(MAXH), .WIN_FRUITS(WINF), .HIT_FRAMES(HITF),
        .BLINK_FRAMES(BLINKF), .END_FRAMES(ENDF)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_key(start_key),
        .current_lives(current_lives), .fruit_cntr(fruit_cntr), .game_state(game_state),
        .play_enable(play_enable), .player_visible(player_visible),
        .show_game_over(show_game_over), .show_win(show_win), .counters_clear(counters_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_frames = 0; m_lives = 0; m_key = 0; m_armed = 0; m_clear = 0;
    endtask

    task automatic model_step();
        int  nst;
        bit  rise;
        bit  hit;
        rise = start_key && !m_key && m_armed;
        hit  = (int'(current_lives) != m_lives);
        nst  = m_st;
        case (m_st)
            0: if (rise) nst = 1;
            1: begin
                if (current_lives == MAXH) nst = 3;
                else if (hit) nst = 2;
                else if (fruit_cntr >= WINF) nst = 4;
            end
            2: begin
                if (current_lives == MAXH) nst = 3;
                else if (startOfFrame && (m_frames + 1 == HITF)) nst = 1;
            end
            default: begin
                if (rise) nst = 0;
                else if (startOfFrame && (m_frames + 1 == ENDF)) nst = 0;
            end
        endcase
        m_clear = (m_st == 0) && (nst == 1);
        m_lives = m_clear ? 0 : int'(current_lives);
        m_key   = start_key;
        if (!start_key) m_armed = 1;
        if (nst != m_st) m_frames = 0;
        else if (startOfFrame && m_frames < 255) m_frames++;
        m_st = nst;
    endtask

    function automatic int model_vis();
        if (m_st == 3) return 0;
        if (m_st == 2) return (m_frames / BLINKF) % 2;
        return 1;
    endfunction

    task automatic step(input bit k, input bit s, input int l, input int f);
        start_key     = k;
        startOfFrame  = s;
        current_lives = l[1:0];
        fruit_cntr    = f[3:0];
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_state(input string tag, input int st, input bit clr, input bit vis);
        chk({tag, " state"}, int'(game_state), st);
        chk({tag, " clear"}, int'(counters_clear), int'(clr));
        chk({tag, " visible"}, int'(player_visible), int'(vis));
        chk({tag, " play_en"}, int'(play_enable), (st == 1) ? 1 : 0);
        chk({tag, " over"}, int'(show_game_over), (st == 3) ? 1 : 0);
        chk({tag, " win"}, int'(show_win), (st == 4) ? 1 : 0);
    endtask

    task automatic do_reset(input bit k);
        start_key = k;
        reset = 1'b1;
        #1;
        check_state("reset", 0, 1'b0, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit rk;
        int rl;
        int rf;
        reset = 1'b1; startOfFrame = 1'b0; start_key = 1'b0;
        current_lives = 2'd0; fruit_cntr = 4'd0;

        tbl = '{
            '{0, 0, 0, 0, 0, 0, 1},
            '{1, 0, 0, 0, 1, 1, 1},
            '{1, 0, 0, 0, 1, 0, 1},
            '{0, 0, 1, 0, 2, 0, 0},
            '{0, 1, 1, 0, 2, 0, 1},
            '{0, 0, 1, 0, 2, 0, 1},
            '{0, 1, 1, 0, 2, 0, 0},
            '{0, 1, 1, 0, 1, 0, 1},
            '{0, 0, 2, 0, 2, 0, 0},
            '{0, 0, 3, 0, 3, 0, 0},
            '{0, 0, 0, 0, 3, 0, 0},
            '{0, 1, 0, 0, 3, 0, 0},
            '{1, 0, 0, 0, 0, 0, 1},
            '{0, 0, 0, 0, 0, 0, 1}
        };

        do_reset(1'b0);

        // start, hit freeze with blinking, game over latched through lives wrap, key back to idle
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].key, tbl[i].sof, tbl[i].lives, tbl[i].fruit);
            check_state($sformatf("vec%0d", i), tbl[i].st, tbl[i].clr, tbl[i].vis);
        end

        // win, then end-screen timeout after ENDF frames
        step(1, 0, 0, 0);   check_state("win start", 1, 1, 1);
        step(0, 0, 0, 10);  check_state("win entry", 4, 0, 1);
        repeat (4) step(0, 1, 0, 10);
        check_state("win hold", 4, 0, 1);
        step(0, 1, 0, 10);  check_state("win timeout", 0, 0, 1);

        // simultaneous hit and win resolves as hit; win is taken on the first play cycle after freeze
        step(1, 0, 0, 0);   check_state("prio start", 1, 1, 1);
        step(0, 0, 1, 0);   check_state("prio hit1", 2, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        check_state("prio resume1", 1, 0, 1);
        step(0, 0, 2, 10);  check_state("prio hit2", 2, 0, 0);
        repeat (3) step(0, 1, 2, 10);
        check_state("prio resume2", 1, 0, 1);
        step(0, 0, 2, 10);  check_state("prio win", 4, 0, 1);

        // reset during freeze with the key held: no clear, and a fresh press is needed
        step(1, 0, 2, 0);   check_state("rst exitwin", 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);   check_state("rst start", 1, 1, 1);
        step(1, 0, 1, 0);   check_state("rst hit", 2, 0, 0);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            check_state($sformatf("rst held%0d", i), 0, 0, 1);
        end
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);   check_state("rst repress", 1, 1, 1);

        // random run against the reference model
        rk = 1'b1; rl = 0; rf = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) == 0) do_reset(rk);
            if ($urandom_range(0, 7) == 0) rk = ~rk;
            if ($urandom_range(0, 11) == 0) rl = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rf = int'($urandom_range(0, 15));
            step(rk, ($urandom_range(0, 2) == 0), rl, rf);
            check_state($sformatf("rnd%0d", c), m_st, m_clear, bit'(model_vis()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Round-level game state machine sitting directly downstream of the lives/score counter block. It consumes the hit count (`current_lives`) and collected-fruit count (`fruit_cntr`), then decides when play runs, freezes after a hit, ends in game-over or win, and restarts. Its outputs drive sprite movement enables, player blinking, end-screen overlays and the clear pulse that restarts the counter block.

## Interface
Parameters:
- `MAX_HITS`, default 3: hit count that ends the game.
- `WIN_FRUITS`, default 10: fruit count that wins the round.
- `HIT_FRAMES`, default 60: frames of freeze after a hit. Legal range 1..255.
- `BLINK_FRAMES`, default 4: frames per blink half-period during freeze. Legal range 1..255.
- `END_FRAMES`, default 180: frames an end screen is shown before auto-return to IDLE. Legal range 1..255.

Ports:
- `clk`  in  1  system clock (single clock domain).
- `reset`  in  1  asynchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `start_key`  in  1  level from the start button, already debounced.
- `current_lives`  in  2  hit count from the counter block.
- `fruit_cntr`  in  4  fruits collected, from the counter block.
- `game_state`  out  3  encoded state: IDLE=0, PLAY=1, HIT=2, GAME_OVER=3, WIN=4.
- `play_enable`  out  1  high only in PLAY; gates player and monster motion.
- `player_visible`  out  1  player sprite draw enable.
- `show_game_over`  out  1  game-over overlay enable.
- `show_win`  out  1  win overlay enable.
- `counters_clear`  out  1  one-cycle pulse. The top level ORs it into the counter block's reset.

## Operation
- Every clock, register `start_key` into `key_d`. `start_rise = start_key & ~key_d`.
- Every clock, register `current_lives` into `lives_d`. `hit_event = (current_lives != lives_d)`.
- An 8-bit `frame_cnt` increments on `startOfFrame`, is cleared on every state entry, and does not wrap. It saturates at 255.
- IDLE:
  - On `start_rise`: go to PLAY and pulse `counters_clear` for that cycle.
- PLAY: conditions are checked in this priority order, one transition per cycle:
  1. `current_lives == MAX_HITS` → GAME_OVER.
  2. `hit_event` → HIT.
  3. `fruit_cntr >= WIN_FRUITS` → WIN.
- HIT:
  - `current_lives == MAX_HITS` → GAME_OVER, taking priority.
  - Otherwise, on the `startOfFrame` that makes `frame_cnt` reach `HIT_FRAMES` → PLAY.
  - Fruit count is ignored in HIT and re-evaluated on the first PLAY cycle.
  - Further hit events while in HIT do not restart the timer.
- GAME_OVER and WIN:
  - On `start_rise` → IDLE.
  - Otherwise, on the `startOfFrame` that makes `frame_cnt` reach `END_FRAMES` → IDLE.
  - Counter inputs are ignored.
- The counter block wraps its hit count from `MAX_HITS` back to 0. GAME_OVER is therefore latched on the first observation of `MAX_HITS`; later wrapping has no effect.
- `player_visible`:
  - 1 in every state except HIT and GAME_OVER.
  - In HIT, starts at 0 on entry and toggles on each `startOfFrame` where `frame_cnt` is a multiple of `BLINK_FRAMES`.
  - In GAME_OVER it is 0.
- `lives_d` is forced to 0 in the cycle `counters_clear` is high, so the counter's return to 0 does not register as a hit.
- An unreachable `game_state` encoding recovers to IDLE on the next clock.

## Timing
- All outputs are registered. A state change appears on `game_state` and the decoded outputs one clock after the triggering input is sampled.
- `counters_clear` is high for exactly one clock, coincident with the first PLAY cycle.
- Hit response: a `current_lives` change at cycle N gives `game_state = HIT` and `play_enable = 0` at N+1.
- Freeze length: exactly `HIT_FRAMES` `startOfFrame` pulses after HIT entry. PLAY becomes visible one clock after the final pulse.
- A `startOfFrame` coinciding with a state transition is counted in the new state only if it arrives after entry. The entry cycle clears `frame_cnt`.
- Reset values:
  - `game_state` = IDLE.
  - `play_enable` = 0, `player_visible` = 1.
  - `show_game_over` = 0, `show_win` = 0, `counters_clear` = 0.
  - `frame_cnt` = 0, `key_d` = 0, `lives_d` = 0.
- Reset asserted mid-round returns everything to these values immediately, with no clear pulse.
- A start key held through reset does not start a game; a fresh rising edge is required.
- Simultaneous hit and win in PLAY resolves as HIT. Simultaneous `MAX_HITS` and win resolves as GAME_OVER.

## Test plan
- Start: reset, then raise `start_key` → next clock `game_state = 1`, `counters_clear` high for one cycle, `play_enable = 1`.
- Hit and freeze (`HIT_FRAMES = 3`, `BLINK_FRAMES = 1`): `current_lives` 0→1 in PLAY → `game_state = 2` next clock. `player_visible` reads 0,1,0 across the three frames. PLAY resumes one clock after the third `startOfFrame`.
- Game over: drive `current_lives` to 3 during HIT → GAME_OVER next clock with `show_game_over = 1`. A wrap of `current_lives` back to 0 leaves the state at 3.
- Win: `fruit_cntr` = 10 in PLAY → `game_state = 4`, `show_win = 1`. After `END_FRAMES = 5` frames → IDLE, with all overlays 0.
- Priority: in the same cycle drive `current_lives` 1→2 and `fruit_cntr` = 10 → HIT. After the freeze the first PLAY cycle goes to WIN.
- Reset mid-HIT with `start_key` held high → IDLE, no `counters_clear`. Releasing and re-pressing the key starts a round.
